// File: rtl/mod_pow2_scaler_pkg.sv
// Shared definitions for the modular power-of-two scaler: FSM encodings and
// the default datapath width.
package mod_defs;

  localparam int unsigned DEF_BITWIDTH = 32;
  localparam int unsigned DEF_SHIFTW   = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mod_doubler.sv
// Combinational modular doubling: oAcc = (2*iAcc) mod iMod, for iAcc < iMod.
module mod_doubler
  import mod_defs::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH
) (
  input  logic [BITWIDTH-1:0] iAcc,
  input  logic [BITWIDTH-1:0] iMod,
  output logic [BITWIDTH-1:0] oAcc
);

  // One extra bit keeps the carry of the doubling, so moduli close to
  // 2^BITWIDTH still reduce correctly.
  logic [BITWIDTH:0] dbl;
  logic [BITWIDTH:0] mod_ext;
  logic [BITWIDTH:0] diff;

  assign dbl     = {iAcc, 1'b0};
  assign mod_ext = {1'b0, iMod};
  assign diff    = dbl - mod_ext;
  assign oAcc    = (dbl >= mod_ext) ? diff[BITWIDTH-1:0] : dbl[BITWIDTH-1:0];

endmodule

// File: rtl/mod_pow2_scaler.sv
// Iterative modular scaler: oData = (iData * 2^iShift) mod iMod, one modular
// doubling per clock, with valid/ready on both request and result sides.
module mod_pow2_scaler
  import mod_defs::*;
#(
  parameter int unsigned BITWIDTH = DEF_BITWIDTH,
  parameter int unsigned SHIFTW   = DEF_SHIFTW
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [SHIFTW-1:0]   iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oBusy,
  output logic [1:0]          oDbgState
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds with stable data until the transfer.

  logic [1:0]          state_q, state_d;
  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic [BITWIDTH-1:0] mod_q, mod_d;
  logic [SHIFTW-1:0]   cnt_q, cnt_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic [BITWIDTH-1:0] dbl_acc;

  mod_doubler #(
    .BITWIDTH (BITWIDTH)
  ) u_mod_doubler (
    .iAcc (acc_q),
    .iMod (mod_q),
    .oAcc (dbl_acc)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          acc_d = iData;
          mod_d = iMod;
          cnt_d = iShift;
          if (iShift == '0) begin
            state_d = ST_DONE;
            data_d  = iData;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = dbl_acc;
        cnt_d = cnt_q - 1'b1;
        // The last doubling lands directly in the result register.
        if (cnt_q <= SHIFTW'(1)) begin
          state_d = ST_DONE;
          data_d  = dbl_acc;
        end
      end
      ST_DONE: begin
        if (iReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign oReady    = (state_q == ST_IDLE);
  assign oBusy     = (state_q != ST_IDLE);
  assign oValid    = (state_q == ST_DONE);
  assign oData     = data_q;
  assign oDbgState = state_q;

endmodule

// File: tb/tb_mod_pow2_scaler.sv
// Bench for mod_pow2_scaler: directed cases plus random requests, results
// checked by a queue-based scoreboard against an arithmetic reference.
module tb_mod_pow2_scaler;

  localparam int W  = 32;
  localparam int SW = 5;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_data;
  logic [W-1:0]  i_mod;
  logic [SW-1:0] i_shift;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_data;
  logic          o_busy;
  logic [1:0]    dbg_state;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit   prev_valid = 0;

  mod_pow2_scaler #(.BITWIDTH(W), .SHIFTW(SW)) dut (
    .iClk      (clk),
    .iRstN     (rst_n),
    .iValid    (i_valid),
    .oReady    (o_ready),
    .iData     (i_data),
    .iMod      (i_mod),
    .iShift    (i_shift),
    .oValid    (o_valid),
    .iReady    (i_ready),
    .oData     (o_data),
    .oBusy     (o_busy),
    .oDbgState (dbg_state)
  );

  // Clock / reset
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: (d * 2^s) mod m using wide integer arithmetic.
  function automatic logic [W-1:0] ref_scale(input logic [W-1:0] d, input logic [W-1:0] m,
                                             input int s);
    logic [63:0] p2, prod;
    p2   = (64'd1 << s) % {32'd0, m};
    prod = {32'd0, d} * p2;
    return W'(prod % {32'd0, m});
  endfunction

  // Driver: returns the edge index at which the request was accepted.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] m, input int s,
                      output int acc_edge);
    bit ok;
    exp_t e;
    acc_edge = -1;
    @(negedge clk);
    i_valid = 1;
    i_data  = d;
    i_mod   = m;
    i_shift = SW'(s);
    for (int k = 0; k < 200; k++) begin
      ok = o_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc_edge = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc_edge < 0) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.data = ref_scale(d, m, s);
      e.cyc  = acc_edge + s;
      exp_q.push_back(e);
    end
    @(negedge clk);
    i_valid = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy_mode == 0) i_ready = 1;
      else if (rdy_mode == 1) i_ready = 1'($urandom_range(0, 1));
      else i_ready = 0;
      chk("busy_vs_ready", W'(o_busy), W'(!o_ready));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          if (!prev_valid) chk("latency", W'(cyc), W'(exp_q[0].cyc));
          chk("result", o_data, exp_q[0].data);
          chk("ready_low_in_done", W'(o_ready), 0);
          if (i_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = o_valid;
    end else begin
      prev_valid = 0;
    end
  end

  initial begin
    int e, t;
    logic [W-1:0] m, d;
    i_valid = 0; i_data = 0; i_mod = 1; i_shift = 0; i_ready = 1;
    rst_n = 0;
    #1;
    chk("reset_valid", W'(o_valid), 0);
    chk("reset_data", o_data, 0);
    chk("reset_busy", W'(o_busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", W'(o_ready), 1);

    // Directed cases
    send(32'd5, 32'd13, 3, e);
    drain();
    send(32'd7, 32'd13, 0, e);
    @(posedge clk); #1;             // handshake edge, back to idle
    chk("ready_again_t2", W'(o_ready), 1);
    drain();
    send(32'hFFFF_FFFA, 32'hFFFF_FFFB, 1, e);
    drain();
    send(32'd1, 32'd1000003, 31, e);
    chk("ref_boundary", ref_scale(32'd1, 32'd1000003, 31), 32'd477207);
    drain();
    send(32'd0, 32'd1, 17, e);
    drain();

    // Backpressure: hold iReady low, pulse iValid while busy.
    @(posedge clk); #1;
    rdy_mode = 2;
    send(32'd9, 32'd23, 2, e);
    while (!o_valid && cyc < e + 50) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_valid = 1; i_data = 32'd1; i_mod = 32'd3; i_shift = 5'd4;
    end
    @(negedge clk);
    i_valid = 0;
    @(posedge clk); #1;
    rdy_mode = 0;
    drain();
    chk("idle_after_bp", W'(o_ready), 1);

    // Asynchronous reset in the middle of a run.
    send(32'd4, 32'd97, 10, e);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    exp_q.delete();
    chk("midrun_rst_valid", W'(o_valid), 0);
    chk("midrun_rst_data", o_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_midrun_rst", W'(o_ready), 1);
    send(32'd3, 32'd11, 2, e);
    drain();

    // Random phase
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      rdy_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: m = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
        1: m = 32'($urandom_range(1, 64));
        2: m = 32'd1;
        default: m = $urandom | 32'd1;
      endcase
      d = $urandom % m;
      t = $urandom_range(0, 31);
      send(d, m, t, e);
      if ($urandom_range(0, 3) == 0) drain();
    end
    @(posedge clk); #1;
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
